// File: rtl/dffram_mbist_ctrl.sv
// March C- self-test controller for a single-port DFFRAM; the functional port passes through when idle.
// Optional macro DFFRAM_MBIST_CHECKERBOARD_EN adds a second pass with 0x55/0xAA backgrounds.
module dffram_mbist_ctrl #(
    parameter int AW    = 7,
    parameter int WSIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [AW-1:0]        fail_addr,
    input  logic [WSIZE-1:0]     fn_WE0,
    input  logic                 fn_EN0,
    input  logic [AW-1:0]        fn_A0,
    input  logic [8*WSIZE-1:0]   fn_Di0,
    output logic [8*WSIZE-1:0]   fn_Do0,
    output logic [WSIZE-1:0]     ram_WE0,
    output logic                 ram_EN0,
    output logic [AW-1:0]        ram_A0,
    output logic [8*WSIZE-1:0]   ram_Di0,
    input  logic [8*WSIZE-1:0]   ram_Do0
);

    localparam int DW = 8 * WSIZE;

    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            phase_q, phase_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic            fail_seen_q, fail_seen_d;
    logic            rd_pend_q, rd_pend_d;
    logic [DW-1:0]   rd_exp_q, rd_exp_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
    logic            pass2_q, pass2_d;
`endif

    logic            op_en, op_we;
    logic [DW-1:0]   op_data;
    logic [DW-1:0]   bg0;
    logic            rd_inv, down, at_end, miscmp;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_seen_d = fail_seen_q;
        rd_pend_d   = 1'b0;
        rd_exp_d    = rd_exp_q;
        rd_addr_d   = rd_addr_q;
        op_en       = 1'b0;
        op_we       = 1'b0;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
        pass2_d     = pass2_q;
        bg0         = pass2_q ? {(DW/2){2'b01}} : '0;
`else
        bg0         = '0;
`endif
        op_data     = bg0;
        rd_inv      = (state_q == M2) || (state_q == M4);
        down        = (state_q == M3) || (state_q == M4);
        at_end      = down ? (addr_q == '0) : (addr_q == '1);

        // Compare for the read issued on the previous edge; only the first miss is kept.
        miscmp = rd_pend_q && (ram_Do0 != rd_exp_q);
        if (miscmp && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_addr_d = rd_addr_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = M0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_seen_d = 1'b0;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
                    pass2_d     = 1'b0;
`endif
                end
            end
            M0: begin
                op_en = 1'b1;
                op_we = 1'b1;
                if (at_end) begin
                    state_d = M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            M1, M2, M3, M4: begin
                op_en = 1'b1;
                if (!phase_q) begin
                    rd_pend_d = 1'b1;
                    rd_exp_d  = rd_inv ? ~bg0 : bg0;
                    rd_addr_d = addr_q;
                    op_data   = rd_exp_d;
                    phase_d   = 1'b1;
                end else begin
                    op_we   = 1'b1;
                    op_data = rd_inv ? bg0 : ~bg0;
                    phase_d = 1'b0;
                    if (at_end) begin
                        case (state_q)
                            M1:      state_d = M2;
                            M2:      state_d = M3;
                            M3:      state_d = M4;
                            default: state_d = M5;
                        endcase
                        addr_d = ((state_q == M2) || (state_q == M3)) ? '1 : '0;
                    end else begin
                        addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    end
                end
            end
            M5: begin
                op_en     = 1'b1;
                rd_pend_d = 1'b1;
                rd_exp_d  = bg0;
                rd_addr_d = addr_q;
                if (at_end) begin
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
                    if (!pass2_q) begin
                        state_d = M0;
                        pass2_d = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d = FLUSH;
                    end
`else
                    state_d = FLUSH;
`endif
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = !fail_seen_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_seen_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_exp_q    <= '0;
            rd_addr_q   <= '0;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
            pass2_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_seen_q <= fail_seen_d;
            rd_pend_q   <= rd_pend_d;
            rd_exp_q    <= rd_exp_d;
            rd_addr_q   <= rd_addr_d;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
            pass2_q     <= pass2_d;
`endif
        end
    end

    always_comb begin
        ram_EN0 = busy_q ? op_en : fn_EN0;
        ram_WE0 = busy_q ? (op_we ? '1 : '0) : fn_WE0;
        ram_A0  = busy_q ? addr_q : fn_A0;
        ram_Di0 = busy_q ? op_data : fn_Di0;
        fn_Do0  = ram_Do0;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_dffram_mbist_ctrl.sv
// Directed bench for dffram_mbist_ctrl with a faultable RAM model and an abstract March C- model.
module tb_dffram_mbist_ctrl;
    localparam int AW = 7;
    localparam int WSIZE = 4;
    localparam int DW = 32;
    localparam int D = 128;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int TOTAL = 10 * D * NPASS;

    // March C- element table, bit e = element Me
    localparam bit [5:0] E_R    = 6'b111110;
    localparam bit [5:0] E_W    = 6'b011111;
    localparam bit [5:0] E_RINV = 6'b010100;
    localparam bit [5:0] E_WINV = 6'b001010;
    localparam bit [5:0] E_DOWN = 6'b011000;

    logic CLK, RST_N, start, busy, done, pass;
    logic [AW-1:0] fail_addr, fn_A0, ram_A0;
    logic [WSIZE-1:0] fn_WE0, ram_WE0;
    logic fn_EN0, ram_EN0;
    logic [DW-1:0] fn_Di0, fn_Do0, ram_Di0, ram_Do0;

    dffram_mbist_ctrl #(.AW(AW), .WSIZE(WSIZE)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .fn_WE0(fn_WE0), .fn_EN0(fn_EN0),
        .fn_A0(fn_A0), .fn_Di0(fn_Di0), .fn_Do0(fn_Do0), .ram_WE0(ram_WE0),
        .ram_EN0(ram_EN0), .ram_A0(ram_A0), .ram_Di0(ram_Di0), .ram_Do0(ram_Do0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int s_edge = 0;
    bit model_active = 0;
    logic mdl_pass;
    logic [AW-1:0] mdl_fa;

    logic [DW-1:0] mem [D];
    logic [DW-1:0] sa1 [D];
    logic [DW-1:0] sa0 [D];
    int cf_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] store_val(int a, logic [DW-1:0] d);
        logic [DW-1:0] v = d;
        if (a == cf_addr) v[1] = v[0];
        return v;
    endfunction

    function automatic logic [DW-1:0] read_val(int a, logic [DW-1:0] s);
        return (s | sa1[a]) & ~sa0[a];
    endfunction

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    always @(posedge CLK) begin
        if (ram_EN0) begin
            if (ram_WE0 != '0) begin
                logic [DW-1:0] nv;
                nv = mem[ram_A0];
                for (int b = 0; b < WSIZE; b++)
                    if (ram_WE0[b]) nv[8*b +: 8] = ram_Di0[8*b +: 8];
                mem[ram_A0] <= store_val(int'(ram_A0), nv);
            end else begin
                ram_Do0 <= read_val(int'(ram_A0), mem[ram_A0]);
            end
        end
    end

    // Whole test run on an abstract array: outcome only.
    task automatic march_model();
        logic [DW-1:0] m [D];
        logic [DW-1:0] bg;
        bit failed = 0;
        int a;
        mdl_fa = '0;
        for (int p = 0; p < NPASS; p++) begin
            bg = (p == 0) ? 32'h0 : 32'h55555555;
            for (int e = 0; e < 6; e++)
                for (int i = 0; i < D; i++) begin
                    a = E_DOWN[e] ? D - 1 - i : i;
                    if (E_R[e] && !failed && read_val(a, m[a]) != (E_RINV[e] ? ~bg : bg)) begin
                        failed = 1;
                        mdl_fa = AW'(a);
                    end
                    if (E_W[e]) m[a] = store_val(a, E_WINV[e] ? ~bg : bg);
                end
        end
        mdl_pass = !failed;
    endtask

    typedef struct packed { logic we; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;

    function automatic op_t exp_op(int n);
        op_t o;
        int k = n % (10 * D);
        logic [DW-1:0] bg = (n >= 10 * D) ? 32'h55555555 : 32'h0;
        int nops, i, sub;
        o = '0;
        for (int e = 0; e < 6; e++) begin
            nops = int'(E_R[e]) + int'(E_W[e]);
            if (k < nops * D) begin
                i = k / nops;
                sub = k % nops;
                o.a = AW'(E_DOWN[e] ? D - 1 - i : i);
                if (E_R[e] && sub == 0) begin
                    o.we = 1'b0;
                    o.d = E_RINV[e] ? ~bg : bg;
                end else begin
                    o.we = 1'b1;
                    o.d = E_WINV[e] ? ~bg : bg;
                end
                return o;
            end
            k -= nops * D;
        end
        return o;
    endfunction

    always @(negedge CLK) begin
        int n;
        op_t o;
        #1;
        chk("fn_Do0_mirror", fn_Do0, ram_Do0);
        if (RST_N && model_active) begin
            n = edge_cnt - s_edge;
            if (n >= 0 && n <= TOTAL) begin
                chk("run_busy", busy, 1'b1);
                chk("run_done", done, 1'b0);
            end
            if (n >= 0 && n < TOTAL) begin
                o = exp_op(n);
                chk("op_en", ram_EN0, 1'b1);
                chk("op_we", ram_WE0, o.we ? 4'hF : 4'h0);
                chk("op_addr", ram_A0, o.a);
                if (o.we) chk("op_data", ram_Di0, o.d);
            end
            if (n == TOTAL) chk("flush_en", ram_EN0, 1'b0);
            if (n == TOTAL + 1) begin
                chk("end_busy", busy, 1'b0);
                chk("end_done", done, 1'b1);
                chk("end_pass", pass, mdl_pass);
                chk("end_fail_addr", fail_addr, mdl_fa);
            end
        end else if (!model_active) begin
            chk("byp_en", ram_EN0, fn_EN0);
            chk("byp_we", ram_WE0, fn_WE0);
            chk("byp_addr", ram_A0, fn_A0);
            chk("byp_di", ram_Di0, fn_Di0);
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < D; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        cf_addr = -1;
    endtask

    task automatic run_test(input string nm, input int mid_start_n, input int abort_n,
                            input logic exp_pass, input logic [AW-1:0] exp_fa, input bit chk_m3);
        int busy_cnt = 0;
        bit fin = 0;
        bit aborted = 0;
        logic [AW-1:0] a_first = '0, a_last = '0;
        march_model();
        chk({nm, "_model_pass"}, mdl_pass, exp_pass);
        chk({nm, "_model_fa"}, mdl_fa, exp_fa);
        @(negedge CLK);
        s_edge = edge_cnt + 1;
        start = 1'b1;
        model_active = 1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < TOTAL + 20; i++) begin
            fn_EN0 = i[0];
            fn_A0 = AW'(i);
            fn_WE0 = 4'hF;
            fn_Di0 = 32'h12345678 ^ i;
            start = (i == mid_start_n);
            if (i == 5 * D) a_first = ram_A0;
            if (i == 7 * D - 1) a_last = ram_A0;
            if (i == abort_n) begin
                model_active = 0;
                RST_N = 1'b0;
                start = 1'b0;
                #2;
                chk({nm, "_abort_busy"}, busy, 1'b0);
                chk({nm, "_abort_done"}, done, 1'b0);
                chk({nm, "_abort_pass"}, pass, 1'b0);
                chk({nm, "_abort_fa"}, fail_addr, '0);
                fn_EN0 = 1'b1;
                #2 chk({nm, "_abort_en1"}, ram_EN0, 1'b1);
                fn_EN0 = 1'b0;
                #2 chk({nm, "_abort_en0"}, ram_EN0, 1'b0);
                @(negedge CLK);
                RST_N = 1'b1;
                aborted = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (done) begin
                fin = 1;
                break;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        if (!aborted) begin
            chk({nm, "_finished"}, fin, 1'b1);
            chk({nm, "_busy_cycles"}, busy_cnt, TOTAL + 1);
            chk({nm, "_pass"}, pass, exp_pass);
            chk({nm, "_fail_addr"}, fail_addr, exp_fa);
            if (chk_m3) begin
                chk({nm, "_m3_first_addr"}, a_first, 7'd127);
                chk({nm, "_m3_last_addr"}, a_last, 7'd0);
            end
        end
        model_active = 0;
        #2;
        fn_EN0 = 1'b0;
        fn_WE0 = '0;
        fn_A0 = '0;
        fn_Di0 = '0;
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b0;
        fn_WE0 = '0;
        fn_EN0 = 1'b0;
        fn_A0 = '0;
        fn_Di0 = '0;
        clear_faults();
        repeat (3) @(negedge CLK);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail_addr", fail_addr, '0);
        RST_N = 1'b1;
        @(negedge CLK);

        fn_WE0 = 4'b0011;
        fn_EN0 = 1'b1;
        fn_A0 = 7'd3;
        fn_Di0 = 32'hDEADBEEF;
        #2;
        chk("idle_we_lit", ram_WE0, 4'b0011);
        chk("idle_addr_lit", ram_A0, 7'd3);
        chk("idle_di_lit", ram_Di0, 32'hDEADBEEF);
        @(negedge CLK);
        fn_WE0 = '0;
        @(negedge CLK);
        #2 chk("idle_read_lo", fn_Do0[15:0], 16'hBEEF);
        fn_EN0 = 1'b0;
        @(negedge CLK);

        run_test("clean", -1, -1, 1'b1, 7'h00, 1);

        clear_faults();
        sa1[7'h2A] = 32'h20;
        run_test("sa1_2a", -1, -1, 1'b0, 7'h2A, 0);

        clear_faults();
        sa1[7'h10] = 32'h8;
        sa0[7'h50] = 32'h80;
        run_test("two_faults", 300, -1, 1'b0, 7'h10, 0);

        clear_faults();
        run_test("abort", -1, 500, 1'b1, 7'h00, 0);

        clear_faults();
        cf_addr = 7;
`ifdef DFFRAM_MBIST_CHECKERBOARD_EN
        run_test("coupling", -1, -1, 1'b0, 7'h07, 0);
`else
        run_test("coupling", -1, -1, 1'b1, 7'h00, 0);
`endif

        clear_faults();
        run_test("clean_again", -1, -1, 1'b1, 7'h00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dffram_mbist_ctrl.md
Name: dffram_mbist_ctrl

Overview:
- Initiator side of the single-port DFFRAM interface (CLK, WE0, EN0, A0, Di0, Do0).
- Sits between functional logic and one DFFRAM macro (default 128x32, 4 byte lanes).
- Idle: functional port passes straight through to the RAM.
- On start: takes the RAM port and runs a March C- self-test, compares read data, and reports pass/fail plus the first failing address.

Parameters:
- AW, 7, address width; DEPTH = 2**AW words.
- WSIZE, 4, byte-lane count; DW = 8*WSIZE data width.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that starts a self-test run.
- busy  out  1  high while the test owns the RAM port.
- done  out  1  sticky completion flag.
- pass  out  1  valid when done=1; 1 = no miscompare.
- fail_addr  out  AW  address of first miscompare; 0 if none.
- fn_WE0  in  WSIZE  functional byte write enables.
- fn_EN0  in  1  functional enable.
- fn_A0  in  AW  functional address.
- fn_Di0  in  DW  functional write data.
- fn_Do0  out  DW  functional read data; always equals ram_Do0.
- ram_WE0  out  WSIZE  to RAM WE0.
- ram_EN0  out  1  to RAM EN0.
- ram_A0  out  AW  to RAM A0.
- ram_Di0  out  DW  to RAM Di0.
- ram_Do0  in  DW  from RAM Do0.

Behaviour:
- Reset values: busy=0, done=0, pass=0, fail_addr=0, FSM=IDLE.
- After reset the ram_* outputs equal the fn_* inputs, combinationally.
- RAM timing: a read is issued by EN0=1, WE0=0 at edge k. Do0 is valid after edge k. The controller registers the compare at edge k+1.
- A write drives EN0=1, WE0 all ones.
- FSM states: IDLE, M0..M5, FLUSH, DONE.
  - M0 = up: w0.
  - M1 = up: r0,w1.
  - M2 = up: r1,w0.
  - M3 = down: r0,w1.
  - M4 = down: r1,w0.
  - M5 = up: r0.
  - Background 0 = all zeros; background 1 = all ones.
- Each operation takes one cycle. An element with a read and a write spends 2 cycles per address. Address counter wraps 0..DEPTH-1 (or DEPTH-1..0 when descending), then the FSM advances.
- start sampled high in IDLE or DONE at edge s:
  - Clears done, pass, fail_addr.
  - Sets busy.
  - First RAM operation is sampled at edge s+1.
- Last read is issued at edge s+10*DEPTH. FLUSH performs the final compare at edge s+10*DEPTH+1, which also sets done=1 and busy=0. Total latency is 10*DEPTH+1 cycles (1281 at defaults).
- Miscompare: ram_Do0 differs from the expected background in any bit.
  - First miscompare latches fail_addr; later ones are ignored.
  - The run always completes.
  - At done, pass = no miscompare seen.
- start while busy is ignored.
- fn_* inputs are ignored while busy; fn_Do0 still mirrors ram_Do0.
- done/pass/fail_addr hold until the next accepted start.
- RST_N low mid-run aborts immediately and returns to reset values. RAM contents are then undefined.

Optional Feature:
- Macro: DFFRAM_MBIST_CHECKERBOARD_EN.
- Defined: after M5, the full M0..M5 sequence repeats once with background 0 = {DW/2{2'b01}} (0x55555555) and background 1 = its inverse (0xAAAAAAAA). The second pass starts on the cycle after the last M5 read, so its w0 overlaps the first pass's last compare. Latency becomes 20*DEPTH+1 (2561). fail_addr captures the first miscompare across both passes.
- Undefined: single pass, all-zeros/all-ones backgrounds only.

Test Plan:
- Fault-free behavioural 128x32 RAM; pulse start -> busy for 1281 cycles; done=1, pass=1, fail_addr=0; during M3 ram_A0 counts 127 down to 0.
- RAM model with bit 5 of word 0x2A stuck-at-1 -> done after 1281 cycles, pass=0, fail_addr=0x2A.
- Stuck faults at 0x10 and 0x50 -> fail_addr=0x10 (first only); run still completes at 1281 cycles.
- Idle bypass: fn_WE0=4'b0011, fn_EN0=1, fn_A0=3, fn_Di0=0xDEADBEEF, then read addr 3 -> ram_* mirror fn_* the same cycle; fn_Do0 shows low half 0xBEEF.
- RST_N low at cycle 500 of a run -> busy=done=pass=0 and fail_addr=0 immediately; ram_EN0 tracks fn_EN0; second start pulse mid-run has no effect (done still at 1281).
- With DFFRAM_MBIST_CHECKERBOARD_EN: fault-free -> done at 2561 cycles, pass=1; coupling fault forcing bit1 := bit0 at addr 0x07 -> pass=0, fail_addr=0x07.
